// File: rtl/counter_pkg.sv
// Shared definitions for the parameterised up/down counter.
//   dir_e          - encoding of the 'up' direction input
//   DEFAULT_WIDTH  - default counter width in bits
package counter_pkg;

    localparam int DEFAULT_WIDTH = 4;

    typedef enum logic {
        DIR_DOWN = 1'b0,
        DIR_UP   = 1'b1
    } dir_e;

endpackage

// File: rtl/counter_prescaler.sv
// Enable prescaler: produces a tick once every PRESCALE enabled cycles.
// Ports:
//   clk      - clock, rising edge
//   rst      - asynchronous active-low reset
//   en       - advance the prescaler this cycle
//   sync_clr - synchronous return to 0 (takes priority over en)
//   tick     - combinational, high on the enabled cycle that completes a period
module counter_prescaler #(
    parameter int PRESCALE = 1
) (
    input  logic clk,
    input  logic rst,
    input  logic en,
    input  logic sync_clr,
    output logic tick
);

    localparam int PW = (PRESCALE > 1) ? $clog2(PRESCALE) : 1;
    localparam logic [PW-1:0] LAST = PW'(PRESCALE - 1);

    logic [PW-1:0] cnt;

    // With PRESCALE=1, LAST is 0 and cnt never leaves 0, so tick == en.
    assign tick = en && (cnt == LAST);

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            cnt <= '0;
        end else if (sync_clr) begin
            cnt <= '0;
        end else if (en) begin
            cnt <= (cnt == LAST) ? '0 : cnt + PW'(1);
        end
    end

endmodule

// File: rtl/param_counter.sv
// Parameterised up/down counter with prescaler, load, clear, wrap pulse
// and sticky overflow flag.
// Ports:
//   clk      - clock, rising edge
//   rst      - asynchronous active-low reset
//   en       - count enable (feeds the prescaler)
//   up       - direction, 1 = up, 0 = down
//   clr      - synchronous clear of count and prescaler (highest priority)
//   load     - synchronous load of load_val, saturated to MAX_VAL
//   load_val - value to load
//   clr_ovf  - clears ovf (a simultaneous wrap wins)
//   q        - registered count, 0..MAX_VAL
//   tc       - combinational terminal count for the current direction
//   wrap     - registered one-cycle pulse after a wrapping edge
//   ovf      - registered sticky wrap flag
module param_counter
    import counter_pkg::*;
#(
    parameter int WIDTH    = DEFAULT_WIDTH,
    parameter int MAX_VAL  = 2**WIDTH - 1,
    parameter int PRESCALE = 1
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             en,
    input  logic             up,
    input  logic             clr,
    input  logic             load,
    input  logic [WIDTH-1:0] load_val,
    input  logic             clr_ovf,
    output logic [WIDTH-1:0] q,
    output logic             tc,
    output logic             wrap,
    output logic             ovf
);

    localparam logic [WIDTH-1:0] MAX_Q = WIDTH'(MAX_VAL);

    logic             tick;
    logic             going_up;
    logic             wrap_set;
    logic [WIDTH-1:0] q_next_count;

    assign going_up = (dir_e'(up) == DIR_UP);

    counter_prescaler #(
        .PRESCALE (PRESCALE)
    ) u_prescaler (
        .clk      (clk),
        .rst      (rst),
        .en       (en),
        .sync_clr (clr | load),
        .tick     (tick)
    );

    assign tc = going_up ? (q == MAX_Q) : (q == '0);

    // q above MAX_VAL (only via misuse) returns to 0 going up without
    // counting as a wrap, since tc is low there.
    always_comb begin
        q_next_count = q;
        if (going_up) begin
            q_next_count = (q >= MAX_Q) ? '0 : q + WIDTH'(1);
        end else begin
            q_next_count = (q == '0) ? MAX_Q : q - WIDTH'(1);
        end
    end

    assign wrap_set = !clr && !load && tick && tc;

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            q    <= '0;
            wrap <= 1'b0;
        end else begin
            wrap <= wrap_set;
            if (clr) begin
                q <= '0;
            end else if (load) begin
                q <= (load_val > MAX_Q) ? MAX_Q : load_val;
            end else if (tick) begin
                q <= q_next_count;
            end
        end
    end

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            ovf <= 1'b0;
        end else if (wrap_set) begin
            ovf <= 1'b1;
        end else if (clr_ovf) begin
            ovf <= 1'b0;
        end
    end

endmodule

// File: tb/tb_param_counter.sv
module tb_param_counter;

    localparam int MAXV = 9;

    logic       clk = 1'b0;
    logic       rst = 1'b0;
    logic       en = 1'b0, up = 1'b0, clr = 1'b0, load = 1'b0, clr_ovf = 1'b0;
    logic [3:0] load_val = 4'd0;

    logic [3:0] q1, q3;
    logic       tc1, wrap1, ovf1, tc3, wrap3, ovf3;

    int checks = 0;
    int failures = 0;

    // reference state: index 0 = PRESCALE 1, index 1 = PRESCALE 3
    int pres[2] = '{1, 3};
    int mq[2], mpre[2], mwrap[2], movf[2];

    always #5 clk = ~clk;

    param_counter #(.WIDTH(4), .MAX_VAL(MAXV), .PRESCALE(1)) dut1 (
        .clk(clk), .rst(rst), .en(en), .up(up), .clr(clr), .load(load),
        .load_val(load_val), .clr_ovf(clr_ovf),
        .q(q1), .tc(tc1), .wrap(wrap1), .ovf(ovf1)
    );

    param_counter #(.WIDTH(4), .MAX_VAL(MAXV), .PRESCALE(3)) dut3 (
        .clk(clk), .rst(rst), .en(en), .up(up), .clr(clr), .load(load),
        .load_val(load_val), .clr_ovf(clr_ovf),
        .q(q3), .tc(tc3), .wrap(wrap3), .ovf(ovf3)
    );

    task automatic check(input string tag, input int obs, input int exp);
        checks++;
        if (obs != exp) begin
            failures++;
            $display("FAIL %s: got %0d expected %0d at %0t", tag, obs, exp, $time);
        end
    endtask

    function automatic void model_reset();
        for (int i = 0; i < 2; i++) begin
            mq[i] = 0; mpre[i] = 0; mwrap[i] = 0; movf[i] = 0;
        end
    endfunction

    function automatic int model_tc(input int i);
        return up ? int'(mq[i] == MAXV) : int'(mq[i] == 0);
    endfunction

    function automatic void model_step();
        for (int i = 0; i < 2; i++) begin
            int wrapped = 0;
            if (clr) begin
                mq[i] = 0; mpre[i] = 0;
            end else if (load) begin
                mq[i] = (int'(load_val) > MAXV) ? MAXV : int'(load_val);
                mpre[i] = 0;
            end else if (en) begin
                if (mpre[i] == pres[i] - 1) begin
                    wrapped = model_tc(i);
                    mq[i] = up ? (mq[i] + 1) % (MAXV + 1) : (mq[i] + MAXV) % (MAXV + 1);
                end
                mpre[i] = (mpre[i] + 1) % pres[i];
            end
            mwrap[i] = wrapped;
            if (wrapped != 0) movf[i] = 1;
            else if (clr_ovf) movf[i] = 0;
        end
    endfunction

    task automatic check_all();
        check("q_p1", int'(q1), mq[0]);
        check("tc_p1", int'(tc1), model_tc(0));
        check("wrap_p1", int'(wrap1), mwrap[0]);
        check("ovf_p1", int'(ovf1), movf[0]);
        check("q_p3", int'(q3), mq[1]);
        check("tc_p3", int'(tc3), model_tc(1));
        check("wrap_p3", int'(wrap3), mwrap[1]);
        check("ovf_p3", int'(ovf3), movf[1]);
    endtask

    task automatic cycle();
        @(posedge clk);
        if (rst) model_step();
        #1;
        check_all();
    endtask

    task automatic set_in(input logic e, input logic u, input logic c,
                          input logic l, input logic [3:0] lv, input logic co);
        en = e; up = u; clr = c; load = l; load_val = lv; clr_ovf = co;
    endtask

    initial begin
        model_reset();
        #12;
        check_all();
        check("tc_reset_down", int'(tc1), 1);
        @(negedge clk);
        rst = 1'b1;

        // count up from reset for 12 cycles
        set_in(1, 1, 0, 0, 0, 0);
        repeat (12) cycle();
        check("q_after12", int'(q1), 2);
        check("ovf_after_wrap", int'(ovf1), 1);

        // down from 0 wraps to MAX
        set_in(0, 0, 1, 0, 0, 1);
        cycle();
        set_in(1, 0, 0, 0, 0, 0);
        cycle();
        check("down_wrap_q", int'(q1), 9);
        check("down_wrap_pulse", int'(wrap1), 1);
        set_in(0, 0, 0, 0, 0, 0);
        cycle();

        // load saturation and clr over load
        set_in(0, 1, 0, 1, 4'd13, 0);
        cycle();
        check("load_sat", int'(q1), 9);
        set_in(0, 1, 1, 1, 4'd5, 0);
        cycle();
        check("clr_over_load", int'(q1), 0);

        // prescale 3, then en dropped mid-prescale
        set_in(1, 1, 0, 0, 0, 0);
        repeat (9) cycle();
        check("presc_q3", int'(q3), 3);
        cycle();
        set_in(0, 1, 0, 0, 0, 0);
        repeat (3) cycle();
        check("presc_hold", int'(q3), 3);
        set_in(1, 1, 0, 0, 0, 0);
        repeat (2) cycle();
        check("presc_resume", int'(q3), 4);

        // clr_ovf colliding with a wrap
        set_in(0, 1, 0, 0, 0, 1);
        cycle();
        check("ovf_cleared", int'(ovf1), 0);
        set_in(0, 1, 0, 1, 4'd9, 0);
        cycle();
        set_in(1, 1, 0, 0, 0, 1);
        cycle();
        check("ovf_set_wins", int'(ovf1), 1);
        set_in(0, 1, 0, 0, 0, 1);
        cycle();
        check("ovf_clr_next", int'(ovf1), 0);

        // asynchronous reset mid-count at q=5
        set_in(1, 1, 1, 0, 0, 0);
        cycle();
        set_in(1, 1, 0, 0, 0, 0);
        repeat (5) cycle();
        check("pre_reset_q", int'(q1), 5);
        #2 rst = 1'b0;
        #1;
        model_reset();
        check("async_q", int'(q1), 0);
        check("async_wrap", int'(wrap1), 0);
        check("async_ovf", int'(ovf1), 0);
        check_all();
        @(negedge clk);
        rst = 1'b1;
        cycle();
        check("resume_after_reset", int'(q1), 1);

        // randomized traffic against the reference model
        for (int n = 0; n < 600; n++) begin
            en       = ($urandom_range(3) != 0);
            if ($urandom_range(7) == 0) up = ~up;
            clr      = ($urandom_range(20) == 0);
            load     = ($urandom_range(15) == 0);
            load_val = 4'($urandom_range(15));
            clr_ovf  = ($urandom_range(7) == 0);
            if ($urandom_range(80) == 0) begin
                #2 rst = 1'b0;
                #1;
                model_reset();
                check_all();
                #1 rst = 1'b1;
            end
            cycle();
        end

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
